// File: rtl/life_pkg.sv
// Shared types and default sizing for the Life generation scheduler.
package life_pkg;

    localparam int GEN_W_DEF       = 16;
    localparam int TIMEOUT_MAX_DEF = 4096;
    localparam int OVR_W_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_CLEAR = 2'd1,
        OP_LOAD  = 2'd2
    } op_e;

endpackage

// File: rtl/life_gen_ctrl.sv
// Generation scheduler: picks the next core operation (clear/load/step/tick),
// pulses it to the Life core, waits for done, and tracks generations, overruns and hangs.
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int GEN_W       = GEN_W_DEF,
    parameter int TIMEOUT_MAX = TIMEOUT_MAX_DEF,
    parameter int OVR_W       = OVR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run,
    input  logic             step_req,
    input  logic             clear_req,
    input  logic             load_req,
    input  logic             core_done,
    output logic             core_start,
    output logic             core_clear,
    output logic             core_load,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic [OVR_W-1:0] ovr_count,
    output logic             hang,
    output state_e           dbg_state_o
);

    localparam int              TO_W    = $clog2(TIMEOUT_MAX + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_MAX - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             pend_q, pend_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             hang_q, hang_d;
    logic             svc_tick;

    // Core handshake: one core_* pulse in ISSUE opens an operation; the first
    // core_done seen in WAIT closes it. done outside WAIT carries no meaning.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pend_d   = pend_q;
        to_d     = to_q;
        gen_d    = gen_q;
        ovr_d    = ovr_q;
        hang_d   = hang_q;
        svc_tick = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    op_d    = OP_CLEAR;
                    state_d = ISSUE;
                end else if (load_req) begin
                    op_d    = OP_LOAD;
                    state_d = ISSUE;
                end else if (step_req && !run) begin
                    op_d    = OP_START;
                    state_d = ISSUE;
                end else if (run && (tick || pend_q)) begin
                    op_d     = OP_START;
                    state_d  = ISSUE;
                    svc_tick = 1'b1;
                end
            end
            ISSUE: begin
                to_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    state_d = IDLE;
                    gen_d   = (op_q == OP_START) ? gen_q + GEN_W'(1) : '0;
                end else if (to_q == TO_LAST) begin
                    state_d = IDLE;
                    hang_d  = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A serviced start consumes one tick token; any token beyond the single
        // pending slot is an overrun.
        if (!run) begin
            pend_d = 1'b0;
        end else if (svc_tick) begin
            pend_d = pend_q & tick;
        end else if (tick) begin
            if (pend_q) begin
                if (ovr_q != '1) ovr_d = ovr_q + OVR_W'(1);
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_START;
            pend_q  <= 1'b0;
            to_q    <= '0;
            gen_q   <= '0;
            ovr_q   <= '0;
            hang_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            to_q    <= to_d;
            gen_q   <= gen_d;
            ovr_q   <= ovr_d;
            hang_q  <= hang_d;
        end
    end

    // Pulses and busy are masked by rst so an aborted operation never leaks a pulse.
    assign core_start  = (state_q == ISSUE) && (op_q == OP_START) && !rst;
    assign core_clear  = (state_q == ISSUE) && (op_q == OP_CLEAR) && !rst;
    assign core_load   = (state_q == ISSUE) && (op_q == OP_LOAD)  && !rst;
    assign busy        = (state_q != IDLE) && !rst;
    assign gen_count   = gen_q;
    assign ovr_count   = ovr_q;
    assign hang        = hang_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Self-checking bench for life_gen_ctrl: directed scenarios plus random traffic,
// all compared cycle by cycle against a tick-token / issue-time reference model.
module tb_life_gen_ctrl;
    import life_pkg::*;

    localparam int TMAX = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tick, run, step_req, clear_req, load_req, core_done;
    logic        core_start, core_clear, core_load, busy, hang;
    logic [15:0] gen_count;
    logic [7:0]  ovr_count;
    state_e      dbg_state;

    life_gen_ctrl #(.GEN_W(16), .TIMEOUT_MAX(TMAX), .OVR_W(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .step_req(step_req),
        .clear_req(clear_req), .load_req(load_req), .core_done(core_done),
        .core_start(core_start), .core_clear(core_clear), .core_load(core_load),
        .busy(busy), .gen_count(gen_count), .ovr_count(ovr_count), .hang(hang),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    // Reference model: an operation is "outstanding" from its choice until done
    // or until TMAX wait cycles after its pulse; ticks are tokens, one may wait.
    int          cyc;
    int          m_op;          // 0 none, 1 start, 2 clear, 3 load
    int          m_issue_cyc;
    logic        m_pend;
    logic [15:0] m_gen;
    logic [7:0]  m_ovr;
    logic        m_hang;

    // Responder and observation
    int   resp_delay = 5;
    int   dn_cnt     = 0;
    int   n_start = 0, n_clear = 0, n_load = 0;
    logic obs_start, obs_busy, obs_hang;
    logic [15:0] obs_gen;
    logic [7:0]  obs_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] kind_vec(input int k);
        case (k)
            1:       return 3'b001;
            2:       return 3'b010;
            3:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        m_op = 0; m_issue_cyc = 0; m_pend = 1'b0;
        m_gen = '0; m_ovr = '0; m_hang = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit idle_now;
        int nxt, tokens;
        bit svc;
        if (rst) begin
            model_reset();
        end else begin
            idle_now = (m_op == 0);
            nxt = 0;
            svc = 1'b0;
            if (idle_now) begin
                if (clear_req)                nxt = 2;
                else if (load_req)            nxt = 3;
                else if (step_req && !run)    nxt = 1;
                else if (run && (tick || m_pend)) begin
                    nxt = 1;
                    svc = 1'b1;
                end
            end else if (cyc > m_issue_cyc) begin
                if (core_done) begin
                    m_gen = (m_op == 1) ? m_gen + 16'd1 : 16'd0;
                    m_op  = 0;
                end else if (cyc - m_issue_cyc == TMAX) begin
                    m_hang = 1'b1;
                    m_op   = 0;
                end
            end
            if (!run) begin
                m_pend = 1'b0;
            end else begin
                tokens = int'(m_pend) + int'(tick);
                if (svc) tokens--;
                if (tokens > 1) begin
                    if (m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
                    tokens = 1;
                end
                m_pend = (tokens == 1);
            end
            if (nxt != 0) begin
                m_op        = nxt;
                m_issue_cyc = cyc + 1;
                exp_q.push_back(kind_vec(nxt));
            end
        end
        cyc++;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle();
        logic [2:0] dvec, mvec;
        @(negedge clk);
        dvec = {core_load, core_clear, core_start};
        mvec = (m_op != 0 && cyc == m_issue_cyc && !rst) ? kind_vec(m_op) : 3'b000;
        check("pulse", 32'(dvec), 32'(mvec));
        check("busy", 32'(busy), 32'(m_op != 0 && !rst));
        check("gen_count", 32'(gen_count), 32'(m_gen));
        check("ovr_count", 32'(ovr_count), 32'(m_ovr));
        check("hang", 32'(hang), 32'(m_hang));
        if (dvec != 3'b000) begin
            if (exp_q.size() == 0) check("pulse_unexpected", 32'(dvec), 32'd0);
            else check("pulse_order", 32'(dvec), 32'(exp_q.pop_front()));
            if (resp_delay > 0) dn_cnt = resp_delay;
        end
        n_start += int'(core_start);
        n_clear += int'(core_clear);
        n_load  += int'(core_load);
        obs_start = core_start; obs_busy = busy; obs_hang = hang;
        obs_gen = gen_count; obs_ovr = ovr_count;
        @(posedge clk);
        model_step();
        #1;
        tick = 1'b0; step_req = 1'b0; clear_req = 1'b0; load_req = 1'b0;
        core_done = 1'b0;
        if (dn_cnt > 0) begin
            dn_cnt--;
            if (dn_cnt == 0) core_done = 1'b1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (!obs_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle_timeout", 32'(ok), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0, c0, l0;
        rst = 1'b1; run = 1'b1; tick = 1'b1;
        step_req = 1'b0; clear_req = 1'b0; load_req = 1'b0; core_done = 1'b0;
        cyc = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset with run/tick held high
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            cycle();
            check("rst_start", 32'(obs_start), 32'd0);
            check("rst_busy", 32'(obs_busy), 32'd0);
            check("rst_state", 32'(dbg_state), 32'(IDLE));
        end
        rst = 1'b0; tick = 1'b1;
        cycle();
        check("post_rst_no_pulse", 32'(obs_start), 32'd0);
        cycle();
        check("first_start_latency", 32'(obs_start), 32'd1);
        repeat (10) cycle();
        do_reset(1);

        // Free-run: tick every 20 cycles, done 5 cycles after start
        resp_delay = 5;
        s0 = n_start;
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1;
            cycle();
            repeat (19) cycle();
        end
        check("freerun_starts", 32'(n_start - s0), 32'd10);
        check("freerun_gen", 32'(obs_gen), 32'd10);
        check("freerun_ovr", 32'(obs_ovr), 32'd0);

        // Overrun: ticks every 4 cycles, done 10 cycles after start
        resp_delay = 10;
        for (int i = 0; i < 550; i++) begin
            tick = 1'b1;
            cycle();
            repeat (3) cycle();
        end
        check("overrun_saturated", 32'(obs_ovr), 32'd255);
        run = 1'b0;
        repeat (20) cycle();
        check("overrun_drained", 32'(obs_busy), 32'd0);

        // Single step while paused
        do_reset(1);
        run = 1'b0; resp_delay = 2;
        s0 = n_start;
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            cycle();
            repeat (9) cycle();
        end
        check("step_starts", 32'(n_start - s0), 32'd3);
        check("step_gen", 32'(obs_gen), 32'd3);
        run = 1'b1;
        s0 = n_start;
        step_req = 1'b1;
        cycle();
        repeat (9) cycle();
        check("step_ignored_in_run", 32'(n_start - s0), 32'd0);

        // Priority: clear beats load beats tick; tick survives as pending
        s0 = n_start; c0 = n_clear; l0 = n_load;
        clear_req = 1'b1; load_req = 1'b1; tick = 1'b1;
        cycle();
        wait_idle(50);
        check("prio_clear_count", 32'(n_clear - c0), 32'd1);
        check("prio_load_count", 32'(n_load - l0), 32'd0);
        check("prio_no_start_yet", 32'(n_start - s0), 32'd0);
        check("prio_gen_cleared", 32'(obs_gen), 32'd0);
        repeat (10) cycle();
        check("prio_pending_start", 32'(n_start - s0), 32'd1);
        check("prio_gen_after", 32'(obs_gen), 32'd1);

        // Hang: no core_done ever
        do_reset(1);
        run = 1'b1; resp_delay = 0;
        tick = 1'b1;
        cycle();
        repeat (16) cycle();
        cycle();
        check("hang_not_yet", 32'(obs_hang), 32'd0);
        check("hang_busy_last_wait", 32'(obs_busy), 32'd1);
        cycle();
        check("hang_set", 32'(obs_hang), 32'd1);
        check("hang_busy_dropped", 32'(obs_busy), 32'd0);
        check("hang_gen_unchanged", 32'(obs_gen), 32'd0);
        resp_delay = 3;
        s0 = n_start;
        tick = 1'b1;
        cycle();
        repeat (8) cycle();
        check("hang_restart", 32'(n_start - s0), 32'd1);
        check("hang_sticky", 32'(obs_hang), 32'd1);
        do_reset(1);
        cycle();
        check("hang_cleared_by_rst", 32'(obs_hang), 32'd0);

        // Random traffic
        run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) run = ~run;
            rst       = ($urandom_range(0, 499) == 0);
            tick      = ($urandom_range(0, 5) == 0);
            step_req  = ($urandom_range(0, 19) == 0);
            clear_req = ($urandom_range(0, 59) == 0);
            load_req  = ($urandom_range(0, 59) == 0);
            core_done = core_done | ($urandom_range(0, 49) == 0);
            resp_delay = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            cycle();
        end

        // Drain and final report
        rst = 1'b0; run = 1'b0; resp_delay = 2;
        repeat (40) cycle();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
- Generation scheduler for the Life core.
- Decides when the core computes its next generation: free-running from the periodic timer pulse, single-step on request, or clear/seed.
- Issues one start pulse per generation, waits for the core's done handshake, counts generations, and flags overruns and hangs.
- Sits between the Timer instance / user controls and the Life array core.

Parameters:
- GEN_W, 16, width of generation counter.
- TIMEOUT_MAX, 4096, max cycles to wait for core_done before declaring a hang.
- OVR_W, 8, width of saturating overrun counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle pulse from Timer (trigger).
- run  input  1  level; 1 = free-run on ticks, 0 = paused.
- step_req  input  1  one-cycle pulse; advance one generation while paused.
- clear_req  input  1  one-cycle pulse; clear array.
- load_req  input  1  one-cycle pulse; load seed pattern.
- core_done  input  1  one-cycle pulse from core; current operation finished.
- core_start  output  1  one-cycle pulse; compute next generation.
- core_clear  output  1  one-cycle pulse; clear array.
- core_load  output  1  one-cycle pulse; load seed.
- busy  output  1  high while an operation is outstanding.
- gen_count  output  GEN_W  generations completed since last clear/load.
- ovr_count  output  OVR_W  saturating count of ticks that arrived while busy.
- hang  output  1  sticky; core_done timeout occurred.

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; all outputs 0; pending-tick flag 0; timeout counter 0. Reset mid-operation aborts at once. No pulse is emitted in the reset cycle or the cycle after it.
- States: IDLE, ISSUE, WAIT.
- IDLE request priority, sampled each cycle: clear_req > load_req > step_req (only when run=0) > (tick or pending) (only when run=1).
- Chosen request latched as op. Next cycle → ISSUE.
- step_req while run=1 is ignored.
- ISSUE: assert exactly one of core_clear/core_load/core_start for one cycle. busy=1. Timeout counter ← 0. → WAIT.
- WAIT: busy=1; timeout counter increments each cycle.
  - core_done → IDLE. Update counters by op:
    - start: gen_count+1, wraps modulo 2^GEN_W.
    - clear or load: gen_count ← 0.
  - Counter reaches TIMEOUT_MAX with no core_done: hang←1 (sticky until rst) → IDLE, gen_count unchanged.
  - core_done in the same cycle as the timeout: done wins, no hang.
- busy is 1 in ISSUE and WAIT; 0 in IDLE.
- Latency: request in IDLE at cycle N → core_* pulse at cycle N+1 → IDLE earliest at cycle N+3, if core_done arrives at N+2.
- Tick while not IDLE (ISSUE/WAIT), run=1:
  - If pending=0: pending←1.
  - Else: ovr_count+1, saturating at all-ones.
  - Pending is one deep.
- Pending serviced in IDLE like a tick, if no higher-priority request; then cleared.
- run→0 clears pending.
- Tick and done in the same cycle while in WAIT: tick sets pending; it is serviced on the next IDLE cycle.
- clear_req/load_req/step_req arriving while busy are dropped (no queue). Software must poll busy.
- core_done in IDLE or ISSUE is ignored.
- Exactly one core_* output is high in any cycle, or none.

Decomposition:
- Package life_pkg:
  - state enum {IDLE, ISSUE, WAIT}.
  - op enum {OP_START, OP_CLEAR, OP_LOAD}.
  - Default GEN_W/TIMEOUT_MAX constants.
- No sub-module; single FSM with counters. The existing Timer drives tick externally.

Test Plan:
- Reset: rst=1 for 3 cycles with tick/run=1 → all outputs 0; first core_start no earlier than 2 cycles after rst falls.
- Free-run: run=1, tick every 20 cycles, core_done 5 cycles after each start → one core_start per tick; gen_count=10 after 10 ticks; ovr_count=0.
- Overrun: run=1, ticks every 4 cycles, core_done 10 cycles after start → pending serviced back-to-back; ovr_count increments for each extra tick and saturates at 255.
- Step: run=0, three step_req pulses spaced 10 cycles apart, done after 2 cycles → 3 core_start pulses, gen_count=3; step_req with run=1 → no pulse.
- Priority/clear: clear_req, load_req and tick all in one IDLE cycle with run=1 → core_clear only, then gen_count=0; tick serviced afterwards as pending.
- Hang: TIMEOUT_MAX=16, core_start with no core_done → hang=1 at cycle 16 of WAIT, busy=0. Next tick → new core_start. hang stays 1 until rst.
